// File: rtl/logic_reduce_pkg.sv
// Shared types and elaboration helpers for the pipelined logic-reduction tree.
package logic_reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_NAND = 2'b01,
    OP_OR   = 2'b10,
    OP_NOR  = 2'b11
  } op_e;

  // Control that travels alongside each stage's data.
  typedef struct packed {
    logic valid;
    op_e  op;
  } stage_ctl_t;

  // Padding leaf value: neutral element of the pairwise operator (1 for AND, 0 for OR).
  function automatic logic identity(input op_e op);
    return (op == OP_AND) || (op == OP_NAND);
  endfunction

  function automatic int unsigned num_levels(input int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Terms per channel after lvl halvings (rounding up).
  function automatic int unsigned lvl_width(input int unsigned n, input int unsigned lvl);
    int unsigned w;
    w = n;
    for (int unsigned i = 0; i < lvl; i++) begin
      w = (w + 1) / 2;
    end
    return w;
  endfunction

  // Per-channel bit offset of level lvl inside the flattened tree vector.
  function automatic int unsigned lvl_offset(input int unsigned n, input int unsigned lvl);
    int unsigned off;
    off = 0;
    for (int unsigned i = 0; i < lvl; i++) begin
      off += lvl_width(n, i);
    end
    return off;
  endfunction

endpackage

// File: rtl/logic_reduce_pipe_reduce_level.sv
// One combinational tree level: pairwise AND/OR per channel, odd tail padded with the identity.
module reduce_level
  import logic_reduce_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned N_IN   = 4,
  parameter int unsigned N_OUT  = 2
) (
  input  op_e                      op,
  input  logic [NUM_CH*N_IN-1:0]   din,
  output logic [NUM_CH*N_OUT-1:0]  dout_c
);

  logic               pad_bit;
  logic [2*N_OUT-1:0] leaves;

  assign pad_bit = identity(op);

  always_comb begin
    dout_c = '0;
    leaves = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      leaves = {(2*N_OUT){pad_bit}};
      for (int unsigned k = 0; k < N_IN; k++) begin
        leaves[k] = din[c*N_IN + k];
      end
      for (int unsigned j = 0; j < N_OUT; j++) begin
        dout_c[c*N_OUT + j] = op[1] ? (leaves[2*j] | leaves[2*j+1])
                                    : (leaves[2*j] & leaves[2*j+1]);
      end
    end
  end

endmodule

// File: rtl/logic_reduce_pipe.sv
// Pipelined multi-channel AND/NAND/OR/NOR reducer with valid/ready flow control
// and a saturating count of delivered results.
module logic_reduce_pipe
  import logic_reduce_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [NUM_CH*NUM_IN-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        out_data,
  output logic [CNT_W-1:0]         out_cnt
);

  localparam int unsigned LEVELS   = num_levels(NUM_IN);
  localparam int unsigned TOT_W    = NUM_CH * lvl_offset(NUM_IN, LEVELS + 1);
  localparam int unsigned LAST_LSB = NUM_CH * lvl_offset(NUM_IN, LEVELS);

  logic                    stall_c;
  logic                    adv_c;
  logic [TOT_W-1:0]        lvl_d;
  logic [TOT_W-1:0]        lvl_q;
  stage_ctl_t [LEVELS:0]   ctl_d;
  stage_ctl_t [LEVELS:0]   ctl_q;
  logic [NUM_CH-1:0]       final_c;

  // A held result freezes the whole pipe; bubbles still advance otherwise.
  assign stall_c  = out_valid & ~out_ready;
  assign adv_c    = ~stall_c;
  assign in_ready = adv_c;

  // Level 0 simply captures the incoming beat.
  assign lvl_d[NUM_CH*NUM_IN-1:0] = in_data;
  assign ctl_d[0].valid           = in_valid;
  assign ctl_d[0].op              = op_e'(in_op);

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned W_IN   = lvl_width(NUM_IN, l - 1);
    localparam int unsigned W_OUT  = lvl_width(NUM_IN, l);
    localparam int unsigned LSB_IN = NUM_CH * lvl_offset(NUM_IN, l - 1);
    localparam int unsigned LSB_OUT = NUM_CH * lvl_offset(NUM_IN, l);

    reduce_level #(
      .NUM_CH (NUM_CH),
      .N_IN   (W_IN),
      .N_OUT  (W_OUT)
    ) u_level (
      .op     (ctl_q[l-1].op),
      .din    (lvl_q[LSB_IN +: NUM_CH*W_IN]),
      .dout_c (lvl_d[LSB_OUT +: NUM_CH*W_OUT])
    );

    assign ctl_d[l] = ctl_q[l-1];
  end

  // Data and control for every tree level share one enable.
  always_ff @(posedge clk or negedge rst_n) begin : p_pipe
    if (!rst_n) begin
      lvl_q <= '0;
      ctl_q <= '0;
    end else if (adv_c) begin
      lvl_q <= lvl_d;
      ctl_q <= ctl_d;
    end
  end

  assign final_c = lvl_q[LAST_LSB +: NUM_CH];

  // Output stage applies the NAND/NOR inversion; data only moves with a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin : p_out
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv_c) begin
      out_valid <= ctl_q[LEVELS].valid;
      if (ctl_q[LEVELS].valid) begin
        out_data <= final_c ^ {NUM_CH{ctl_q[LEVELS].op[0]}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_cnt
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (out_valid && out_ready && (out_cnt != {CNT_W{1'b1}})) begin
      out_cnt <= out_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Bench for logic_reduce_pipe: default instance (4 inputs x 2 channels) and a
// padded/saturating instance (3 inputs x 2 channels, 3-bit counter).
module tb_logic_reduce_pipe;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1:0] a_in_op;
  logic [7:0] a_in_data;
  logic [1:0] a_out_data;
  logic [15:0] a_out_cnt;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [1:0] b_in_op;
  logic [5:0] b_in_data;
  logic [1:0] b_out_data;
  logic [2:0] b_out_cnt;

  always #5 clk = ~clk;

  logic_reduce_pipe #(.NUM_IN(4), .NUM_CH(2), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_cnt(a_out_cnt)
  );

  logic_reduce_pipe #(.NUM_IN(3), .NUM_CH(2), .CNT_W(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_cnt(b_out_cnt)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [1:0] exp;
  } vec_t;

  int vectors     = 0;
  int miscompares = 0;
  int a_sent      = 0;
  int b_pops      = 0;

  logic [1:0]  a_q[$];
  logic [1:0]  b_q[$];
  logic [15:0] a_cnt_m;
  logic [2:0]  b_cnt_m;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: count ones per channel; AND needs all set, OR needs any; op[0] inverts.
  function automatic logic [1:0] model(input logic [1:0] op, input logic [7:0] data, input int nin);
    logic [1:0] r;
    int ones;
    for (int c = 0; c < 2; c++) begin
      ones = 0;
      for (int i = 0; i < nin; i++) ones += int'(data[c*nin + i]);
      r[c] = op[1] ? (ones > 0) : (ones == nin);
      r[c] = r[c] ^ op[0];
    end
    return r;
  endfunction

  // Scoreboards and counter models, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      a_q.delete();
      a_cnt_m = '0;
    end else begin
      check("a_cnt", 32'(a_out_cnt), 32'(a_cnt_m));
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) check("a_spurious_out", 32'(a_q.size()), 32'd1);
        else check("a_data", 32'(a_out_data), 32'(a_q.pop_front()));
        if (a_cnt_m != 16'hFFFF) a_cnt_m = a_cnt_m + 16'd1;
      end
      if (a_in_valid && a_in_ready) a_q.push_back(model(a_in_op, a_in_data, 4));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_q.delete();
      b_cnt_m = '0;
      b_pops  = 0;
    end else begin
      check("b_cnt", 32'(b_out_cnt), 32'(b_cnt_m));
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) check("b_spurious_out", 32'(b_q.size()), 32'd1);
        else check("b_data", 32'(b_out_data), 32'(b_q.pop_front()));
        if (b_cnt_m != 3'd7) b_cnt_m = b_cnt_m + 3'd1;
        b_pops++;
      end
      if (b_in_valid && b_in_ready) b_q.push_back(model(b_in_op, {2'b00, b_in_data}, 3));
    end
  end

  // Single isolated beat: checks acceptance, exact latency and result.
  task automatic send_iso(input bit d, input logic [1:0] op, input logic [7:0] data,
                          input logic [1:0] exp);
    int lat;
    logic [1:0] got;
    lat = -1;
    got = '0;
    if (!d) begin
      a_in_op = op; a_in_data = data; a_in_valid = 1'b1; a_sent++;
    end else begin
      b_in_op = op; b_in_data = data[5:0]; b_in_valid = 1'b1;
    end
    @(negedge clk);
    check(d ? "b_iso_ready" : "a_iso_ready", 32'(d ? b_in_ready : a_in_ready), 32'd1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (d ? b_out_valid : a_out_valid) begin
        lat = i;
        got = d ? b_out_data : a_out_data;
        break;
      end
    end
    check(d ? "b_iso_latency" : "a_iso_latency", 32'(lat), 32'd3);
    check(d ? "b_iso_result" : "a_iso_result", 32'(got), 32'(exp));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t a_tab[7];
    vec_t b_tab[6];
    int run, w;
    logic acc, acc_a, acc_b, s6, s7;
    logic [1:0] held;

    a_tab[0] = '{2'b00, 8'b1011_1111, 2'b01};
    a_tab[1] = '{2'b01, 8'b1011_1111, 2'b10};
    a_tab[2] = '{2'b10, 8'b0100_0000, 2'b10};
    a_tab[3] = '{2'b11, 8'b0100_0000, 2'b01};
    a_tab[4] = '{2'b00, 8'b0000_1111, 2'b01};
    a_tab[5] = '{2'b10, 8'b1000_0001, 2'b11};
    a_tab[6] = '{2'b11, 8'b0000_0000, 2'b11};
    b_tab[0] = '{2'b00, 8'b00_011_111, 2'b01};
    b_tab[1] = '{2'b10, 8'b00_100_000, 2'b10};
    b_tab[2] = '{2'b01, 8'b00_111_111, 2'b00};
    b_tab[3] = '{2'b11, 8'b00_000_000, 2'b11};
    b_tab[4] = '{2'b00, 8'b00_111_011, 2'b10};
    b_tab[5] = '{2'b10, 8'b00_000_100, 2'b01};

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_op = '0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_op = '0; b_in_data = '0; b_out_ready = 1'b1;
    #1;
    check("rst_a_valid", 32'(a_out_valid), 32'd0);
    check("rst_a_cnt",   32'(a_out_cnt),   32'd0);
    check("rst_a_ready", 32'(a_in_ready),  32'd1);
    check("rst_b_valid", 32'(b_out_valid), 32'd0);
    check("rst_b_cnt",   32'(b_out_cnt),   32'd0);
    check("rst_b_ready", 32'(b_in_ready),  32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (a_tab[i]) send_iso(1'b0, a_tab[i].op, a_tab[i].data, a_tab[i].exp);
    foreach (b_tab[i]) send_iso(1'b1, b_tab[i].op, b_tab[i].data, b_tab[i].exp);

    // Streaming: 8 back-to-back beats cycling through all ops.
    run = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          a_in_valid = 1'b1; a_in_op = 2'(k % 4); a_in_data = 8'($urandom); a_sent++;
          @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (a_out_valid) run++;
          else if (run > 0) break;
        end
      end
    join
    check("stream_run", 32'(run), 32'd8);
    check("stream_cnt", 32'(a_out_cnt), 32'(a_sent));
    @(posedge clk); #1;

    // Backpressure: consumer stalls for 5 cycles while the producer keeps offering.
    a_out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 12; k++) begin
          a_in_valid = 1'b1; a_in_op = 2'($urandom); a_in_data = 8'($urandom);
          acc = 1'b0;
          for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk); acc = a_in_ready;
            @(posedge clk); #1;
          end
          check("bp_accept", 32'(acc), 32'd1);
          if (acc) a_sent++;
        end
        a_in_valid = 1'b0;
      end
      begin
        w = 0;
        while (!a_out_valid && w < 20) begin @(posedge clk); #1; w++; end
        check("bp_start", 32'(a_out_valid), 32'd1);
        held = a_out_data;
        for (int i = 0; i < 5; i++) begin
          check("bp_in_ready", 32'(a_in_ready), 32'd0);
          check("bp_hold", 32'(a_out_data), 32'(held));
          @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
      end
    join
    w = 0;
    while ((a_q.size() != 0 || a_out_valid) && w < 30) begin @(posedge clk); #1; w++; end
    check("bp_drain", 32'(a_q.size()), 32'd0);
    check("bp_cnt", 32'(a_out_cnt), 32'(a_sent));

    // Random traffic on both instances; upstream holds a beat until taken.
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      acc_a = a_in_valid && a_in_ready;
      acc_b = b_in_valid && b_in_ready;
      @(posedge clk); #1;
      if (!a_in_valid || acc_a) begin
        a_in_valid = ($urandom_range(0, 3) != 0); a_in_op = 2'($urandom); a_in_data = 8'($urandom);
      end
      if (!b_in_valid || acc_b) begin
        b_in_valid = ($urandom_range(0, 3) != 0); b_in_op = 2'($urandom); b_in_data = 6'($urandom);
      end
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rand_a_drain", 32'(a_q.size()), 32'd0);
    check("rand_b_drain", 32'(b_q.size()), 32'd0);
    check("rand_b_sat", 32'(b_out_cnt), 32'd7);

    // Reset while results are in flight.
    for (int k = 0; k < 5; k++) begin
      a_in_valid = 1'b1; a_in_op = 2'($urandom); a_in_data = 8'($urandom);
      b_in_valid = 1'b1; b_in_op = 2'($urandom); b_in_data = 6'($urandom);
      @(posedge clk); #1;
    end
    check("rst_pre_valid", 32'(a_out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_a_valid", 32'(a_out_valid), 32'd0);
    check("rst_mid_b_valid", 32'(b_out_valid), 32'd0);
    check("rst_mid_a_cnt",   32'(a_out_cnt),   32'd0);
    check("rst_mid_b_cnt",   32'(b_out_cnt),   32'd0);
    check("rst_mid_a_ready", 32'(a_in_ready),  32'd1);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stale_a", 32'(a_out_valid), 32'd0);
      check("stale_b", 32'(b_out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Saturation: 10 results into a 3-bit counter.
    s6 = 1'b0; s7 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (t < 10) begin
        b_in_valid = 1'b1; b_in_op = 2'($urandom); b_in_data = 6'($urandom);
      end else begin
        b_in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (b_pops == 6 && !s6) begin check("sat_cnt6", 32'(b_out_cnt), 32'd6); s6 = 1'b1; end
      if (b_pops == 7 && !s7) begin check("sat_cnt7", 32'(b_out_cnt), 32'd7); s7 = 1'b1; end
    end
    check("sat_pops", 32'(b_pops), 32'd10);
    check("sat_hold", 32'(b_out_cnt), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logic_reduce_pipe.md
Name: logic_reduce_pipe

Overview:
- Parametrised, pipelined successor to the two-input static AND cell (NAND stage plus inverter).
- Reduces NUM_IN inputs per channel across NUM_CH independent channels with a selectable operation: AND, NAND, OR or NOR.
- Uses one register level per tree level, with a valid/ready handshake and a saturating result counter.
- Sits between a gate-level datapath and a test/observation harness.

Parameters:
- NUM_IN, 4: inputs reduced per channel; must be >=1.
- NUM_CH, 2: independent channels; must be >=1.
- CNT_W, 16: width of the accepted-result counter.
- Derived, not overridable: LEVELS = clog2(NUM_IN), which is 0 when NUM_IN=1. LAT = LEVELS+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_op  in  2  operation: 00 AND, 01 NAND, 10 OR, 11 NOR.
- in_data  in  NUM_CH*NUM_IN  channel c occupies bits [c*NUM_IN +: NUM_IN].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  NUM_CH  bit c is the result for channel c.
- out_cnt  out  CNT_W  count of accepted results, saturating.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- Values while rst_n=0: all stage valid bits 0, out_valid=0, out_data=0, out_cnt=0. Stage data and op registers are also cleared to 0.
- Acceptance: a beat is accepted on a rising edge when in_valid && in_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall, so it is combinational from out_valid and out_ready.
  - While stall=1, every pipeline register holds its value, including valid bits and op.
  - While stall=0, every stage advances by one. Bubbles (valid=0) propagate without being collapsed.
- Pipeline stages:
  - Stage 0 registers in_data, in_op and in_valid.
  - Stages 1..LEVELS each combine adjacent pairs, halving the term count and rounding up.
  - The output register applies the final inversion for NAND/NOR, driving out_data and out_valid.
  - Latency: with no stalls, a beat accepted at edge k gives out_valid=1 after edge k+LAT. Defaults give LAT=3.
  - Throughput: one beat per cycle.
- Operation selection:
  - The op bit [1] travels with the data through every stage. It selects the pairwise operator: 0 means AND, 1 means OR.
  - The op bit [0] is applied only at the output stage, as an XOR inversion.
  - Beats with different ops may be back-to-back. Each beat uses its own op.
- Padding when NUM_IN is not a power of two: missing leaves take the identity value, 1 for AND and 0 for OR, chosen from the beat's op[1].
- NUM_IN=1: the result is the input bit, optionally inverted. LAT=1.
- out_data keeps its last value while out_valid=0. The value is don't-care to consumers and is not checked by the bench.
- out_cnt:
  - Increments by 1 on each edge where out_valid && out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Simultaneous events: when out_valid && out_ready and a new beat arrives in the same cycle, the pipeline advances and both transfers occur. There is no bubble.
- Reset mid-operation: in-flight beats are discarded. out_valid drops immediately on assertion, asynchronously.
- Invalid in_valid while stalled: ignored, because in_ready=0. The upstream must hold the beat.

Decomposition:
- Package logic_reduce_pkg holds:
  - op_e enum: OP_AND=2'b00, OP_NAND=2'b01, OP_OR=2'b10, OP_NOR=2'b11.
  - Helper function identity(op) returning the padding bit.
- One natural sub-module: reduce_level, combinational. Parameters are the input count and the output count. It does the pairwise AND/OR selected by op[1] and pads with the identity value.
- The top module instantiates reduce_level per level inside a generate loop, with registers plus a shared enable = !stall.

Test Plan:
- Reset: assert rst_n=0 mid-stream, then release → out_valid=0, out_cnt=0, in_ready=1; no stale result appears afterwards.
- Truth table, defaults: op=AND, ch0=4'b1111, ch1=4'b1011 → out_data=2'b01 exactly 3 cycles later. op=NAND with same data → 2'b10. op=OR with ch0=0000, ch1=0100 → 2'b10. op=NOR with same data → 2'b01.
- Streaming: 8 back-to-back beats with alternating ops and out_ready=1 → 8 results on consecutive cycles, in order, out_cnt=8.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 → in_ready=0 from the first stalled cycle; out_data is stable; no beat is lost or duplicated after release; the beat count matches.
- Padding: NUM_IN=3, op=AND with ch0=3'b111 → result 1. op=OR with ch0=3'b000 → result 0. LAT=3.
- Saturation: CNT_W=3, 10 accepted results → out_cnt reads 7 after the 7th result and stays at 7.
